flag_fifo: RTL and testbench

Synchronous single-clock FIFO that buffers actor tokens and produces the registered `full` and `almost_full` status pair consumed by the downstream flow-control `controller`. It is the storage stage directly upstream of that controller. Its status outputs connect straight to the controller's `full`/`almost_full` inputs, and the controller's `enable` gates the producer writing into this FIFO. It also provides a registered read port, an occupancy count and sticky error flags for debug.

---
 rtl/flag_fifo_pkg.sv | 21 ++
 rtl/flag_fifo_ram.sv | 25 ++
 rtl/flag_fifo.sv | 67 ++++++
 tb/tb_flag_fifo.sv | 125 ++++++++++++
 4 files changed

// File: rtl/flag_fifo_pkg.sv
// flag_fifo_pkg: shared width derivations and almost-full threshold helper for flag_fifo
package flag_fifo_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AF_MARGIN = 2;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction
    // Count needs one extra bit so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction
    function automatic int af_level(input int depth, input int margin);
        return depth - margin;
    endfunction
endpackage

// File: rtl/flag_fifo_ram.sv
// fifo_ram: DEPTH x WIDTH simple dual-port RAM, sync write, registered read
// Ports: clk, reset (clears only the read register), we/waddr/wdata write port,
//        re/raddr read request, rdata registered read data (holds when re is low).
module fifo_ram import flag_fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/flag_fifo.sv
// flag_fifo: single-clock FIFO with registered empty/full/almost_full and sticky error flags
// Ports: clk, reset (async, active-high); wr_en/din write side; rd_en read side;
//        dout/dout_valid registered read data; empty/full/almost_full/count status;
//        overflow/underflow sticky rejected-write/rejected-read flags.
module flag_fifo import flag_fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AF_MARGIN = DEF_AF_MARGIN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          din,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count_next;
    logic wa, ra;
    // Acceptance looks only at registered flags: no read-to-write bypass.
    assign wa = wr_en & ~full;
    assign ra = rd_en & ~empty;
    assign count_next = count + CW'(wa) - CW'(ra);
    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk(clk),
        .reset(reset),
        .we(wa),
        .waddr(wptr),
        .wdata(din),
        .re(ra),
        .raddr(rptr),
        .rdata(dout)
    );
    // Flags derive from count_next so they update on the same edge as count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            dout_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wptr        <= wptr + AW'(wa);
            rptr        <= rptr + AW'(ra);
            count       <= count_next;
            empty       <= count_next == '0;
            full        <= count_next == CW'(DEPTH);
            almost_full <= count_next >= CW'(af_level(DEPTH, AF_MARGIN));
            dout_valid  <= ra;
            overflow    <= overflow | (wr_en & full);
            underflow   <= underflow | (rd_en & empty);
        end
    end
endmodule

// File: tb/tb_flag_fifo.sv
// tb_flag_fifo: directed and random checks of flag_fifo against a queue-based model
module tb_flag_fifo;
    localparam int W = 32, D = 8, M = 2;
    logic clk = 0, reset = 1, wr_en = 0, rd_en = 0;
    logic [W-1:0] din = '0, dout;
    logic dout_valid, empty, full, almost_full, overflow, underflow;
    logic [3:0] count;
    int checks = 0, failures = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    logic m_dv = 0, m_ovf = 0, m_unf = 0;
    always #5 clk = ~clk;
    flag_fifo #(.WIDTH(W), .DEPTH(D), .AF_MARGIN(M)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        int n = q.size();
        chk({tag, ".count"}, W'(count), W'(n));
        chk({tag, ".empty"}, W'(empty), W'(n == 0));
        chk({tag, ".full"}, W'(full), W'(n == D));
        chk({tag, ".almost_full"}, W'(almost_full), W'(n >= D - M));
        chk({tag, ".dout"}, dout, m_dout);
        chk({tag, ".dout_valid"}, W'(dout_valid), W'(m_dv));
        chk({tag, ".overflow"}, W'(overflow), W'(m_ovf));
        chk({tag, ".underflow"}, W'(underflow), W'(m_unf));
    endtask
    task automatic model_reset();
        q.delete();
        m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
    endtask
    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input string tag);
        bit was_full, was_empty, wa, ra;
        wr_en = w; din = d; rd_en = r;
        @(posedge clk);
        was_full = q.size() == D;
        was_empty = q.size() == 0;
        wa = w && !was_full;
        ra = r && !was_empty;
        if (w && was_full) m_ovf = 1;
        if (r && was_empty) m_unf = 1;
        if (ra) m_dout = q.pop_front();
        m_dv = ra;
        if (wa) q.push_back(d);
        #1;
        wr_en = 0; rd_en = 0;
        check_all(tag);
    endtask
    task automatic async_reset(input string tag);
        #1 reset = 1;
        model_reset();
        #1 check_all(tag);
        #1 reset = 0;
    endtask
    initial begin
        logic [W-1:0] v;
        repeat (2) @(posedge clk);
        #1 check_all("por");
        reset = 0;
        step(1, 32'h11, 0, "pre");
        step(1, 32'h22, 0, "pre");
        async_reset("rst_async");
        step(1, 32'hA5, 0, "rst_wr");
        chk("rst_wr.count_is_1", W'(count), 32'd1);
        chk("rst_wr.not_empty", W'(empty), 32'd0);
        async_reset("fill_rst");
        for (int i = 1; i <= D; i++) begin
            step(1, W'(i), 0, "fill");
            if (i == 5) chk("fill.af_low_at5", W'(almost_full), 32'd0);
            if (i == 6) chk("fill.af_high_at6", W'(almost_full), 32'd1);
            if (i == 7) chk("fill.full_low_at7", W'(full), 32'd0);
        end
        chk("fill.full_at8", W'(full), 32'd1);
        step(1, 32'h99, 0, "fill9");
        chk("fill9.overflow", W'(overflow), 32'd1);
        chk("fill9.count8", W'(count), 32'd8);
        for (int i = 1; i <= D; i++) begin
            step(0, '0, 1, "drain");
            chk("drain.order", dout, W'(i));
            chk("drain.valid", W'(dout_valid), 32'd1);
        end
        chk("drain.empty", W'(empty), 32'd1);
        step(0, '0, 1, "drain9");
        chk("drain9.underflow", W'(underflow), 32'd1);
        chk("drain9.dout_hold", dout, 32'd8);
        chk("drain9.no_valid", W'(dout_valid), 32'd0);
        async_reset("rw_rst");
        for (int i = 0; i < D; i++) step(1, W'(32'h100 + i), 0, "rw_fill");
        step(1, 32'hDEAD, 1, "rw_full");
        chk("rw_full.count7", W'(count), 32'd7);
        chk("rw_full.overflow", W'(overflow), 32'd1);
        chk("rw_full.dout", dout, 32'h100);
        for (int i = 0; i < 7; i++) step(0, '0, 1, "rw_drain");
        step(1, 32'hBEEF, 1, "rw_empty");
        chk("rw_empty.count1", W'(count), 32'd1);
        chk("rw_empty.no_valid", W'(dout_valid), 32'd0);
        async_reset("wrap_rst");
        for (int i = 0; i < 4; i++) step(1, W'(32'h200 + i), 0, "wrap_pre");
        for (int i = 0; i < 20; i++) begin
            step(1, $urandom, 1, "wrap");
            chk("wrap.count4", W'(count), 32'd4);
        end
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, "mid_fill");
        async_reset("mid_rst");
        chk("mid_rst.count0", W'(count), 32'd0);
        v = $urandom;
        step(1, v, 0, "mid_wr");
        step(0, '0, 1, "mid_rd");
        chk("mid_rd.first_after_reset", dout, v);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45, "rand");
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 60, "rand2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
